// File: rtl/cdb_pkg.sv
// cdb_pkg: shared FU ids, default widths and result entry type for the CDB arbiter
package cdb_pkg;
  localparam int NUM_FU = 3;
  localparam logic [1:0] FU_ALU = 2'd0;
  localparam logic [1:0] FU_LSU = 2'd1;
  localparam logic [1:0] FU_MUL = 2'd2;
  localparam int TAG_W_DEF = 5;
  localparam int DATA_W_DEF = 32;
  typedef struct packed {
    logic [TAG_W_DEF-1:0]  tag;
    logic [DATA_W_DEF-1:0] data;
  } cdb_entry_t;
  function automatic logic [1:0] next_fu(input logic [1:0] f);
    return f == FU_MUL ? FU_ALU : f + 2'd1;
  endfunction
endpackage

// File: rtl/cdb_fifo.sv
// cdb_fifo: small order-preserving result FIFO; pushes while full and pops while empty are dropped
module cdb_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 37
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers ALU/LSU/MUL results and broadcasts one per cycle round-robin on a registered CDB
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = TAG_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [TAG_W-1:0]  alu_reg_addr_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [TAG_W-1:0]  lsu_reg_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  input  logic              mul_valid_i,
  output logic              mul_ready_o,
  input  logic [TAG_W-1:0]  mul_reg_addr_i,
  input  logic [DATA_W-1:0] mul_data_i,
  output logic              cdb_en_o,
  output logic [TAG_W-1:0]  cdb_reg_addr_o,
  output logic [DATA_W-1:0] cdb_data_o,
  output logic [1:0]        cdb_src_o
);
  localparam int W = TAG_W + DATA_W;
  logic [NUM_FU-1:0] valid, full, empty, pop;
  logic [W-1:0] din [NUM_FU];
  logic [W-1:0] head [NUM_FU];
  logic [1:0] last_grant, s0, s1, s2, gnt;
  logic gnt_v;
  assign valid = {mul_valid_i, lsu_valid_i, alu_valid_i};
  assign din[FU_ALU] = {alu_reg_addr_i, alu_data_i};
  assign din[FU_LSU] = {lsu_reg_addr_i, lsu_data_i};
  assign din[FU_MUL] = {mul_reg_addr_i, mul_data_i};
  assign {mul_ready_o, lsu_ready_o, alu_ready_o} = ~full;
  genvar i;
  for (i = 0; i < NUM_FU; i++) begin : g_fifo
    cdb_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
      .clk(clk_i),
      .rst(reset_i),
      .push(valid[i]),
      .pop(pop[i]),
      .din(din[i]),
      .full(full[i]),
      .empty(empty[i]),
      .head(head[i])
    );
  end
  // search order starts one past the last winner
  always_comb begin
    s0 = next_fu(last_grant);
    s1 = next_fu(s0);
    s2 = next_fu(s1);
    gnt = !empty[s0] ? s0 : !empty[s1] ? s1 : s2;
    gnt_v = ~&empty;
    pop = gnt_v ? NUM_FU'(1) << gnt : '0;
  end
  always_ff @(posedge clk_i)
    if (reset_i) begin
      cdb_en_o <= 1'b0;
      cdb_reg_addr_o <= '0;
      cdb_data_o <= '0;
      cdb_src_o <= FU_ALU;
      last_grant <= FU_MUL;
    end else begin
      cdb_en_o <= gnt_v;
      if (gnt_v) begin
        {cdb_reg_addr_o, cdb_data_o} <= head[gnt];
        cdb_src_o <= gnt;
        last_grant <= gnt;
      end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic alu_valid_i = 1'b0, lsu_valid_i = 1'b0, mul_valid_i = 1'b0;
  logic alu_ready_o, lsu_ready_o, mul_ready_o;
  logic [4:0] alu_reg_addr_i = '0, lsu_reg_addr_i = '0, mul_reg_addr_i = '0;
  logic [31:0] alu_data_i = '0, lsu_data_i = '0, mul_data_i = '0;
  logic cdb_en_o;
  logic [4:0] cdb_reg_addr_o;
  logic [31:0] cdb_data_o;
  logic [1:0] cdb_src_o;
  int vectors = 0;
  int miscompares = 0;
  int pc [3];
  int qc [3];
  logic [2:0] rs;
  int s;

  cdb_arbiter #(.DEPTH(2), .TAG_W(5), .DATA_W(32)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_reg_addr_i(alu_reg_addr_i), .alu_data_i(alu_data_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_reg_addr_i(lsu_reg_addr_i), .lsu_data_i(lsu_data_i),
    .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o), .mul_reg_addr_i(mul_reg_addr_i), .mul_data_i(mul_data_i),
    .cdb_en_o(cdb_en_o), .cdb_reg_addr_o(cdb_reg_addr_o), .cdb_data_o(cdb_data_o), .cdb_src_o(cdb_src_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic reset_pulse();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  function automatic logic [4:0] tag_of(input int u, input int k);
    return 5'(u * 10 + k);
  endfunction

  function automatic logic [31:0] data_of(input int u, input int k);
    return 32'((u << 16) | k | 32'hC0000000);
  endfunction

  initial begin
    step();
    step();
    reset_i = 1'b0;
    chk("rst_en", cdb_en_o, 0);
    chk("rst_tag", cdb_reg_addr_o, 0);
    chk("rst_data", cdb_data_o, 0);
    chk("rst_src", cdb_src_o, 0);
    chk("rst_ready", {mul_ready_o, lsu_ready_o, alu_ready_o}, 3'b111);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_en", cdb_en_o, 0);
      chk("idle_ready", {mul_ready_o, lsu_ready_o, alu_ready_o}, 3'b111);
    end
    chk("idle_data", cdb_data_o, 0);

    // single ALU push
    alu_valid_i = 1'b1; alu_reg_addr_i = 5'd5; alu_data_i = 32'hDEADBEEF;
    step();
    alu_valid_i = 1'b0;
    chk("single_no_bypass", cdb_en_o, 0);
    step();
    chk("single_en", cdb_en_o, 1);
    chk("single_tag", cdb_reg_addr_o, 5);
    chk("single_data", cdb_data_o, 32'hDEADBEEF);
    chk("single_src", cdb_src_o, 0);
    step();
    chk("single_en_off", cdb_en_o, 0);
    chk("single_tag_hold", cdb_reg_addr_o, 5);

    // simultaneous push from all three units
    reset_pulse();
    alu_valid_i = 1'b1; alu_reg_addr_i = 5'd1; alu_data_i = 32'h101;
    lsu_valid_i = 1'b1; lsu_reg_addr_i = 5'd2; lsu_data_i = 32'h102;
    mul_valid_i = 1'b1; mul_reg_addr_i = 5'd3; mul_data_i = 32'h103;
    step();
    {alu_valid_i, lsu_valid_i, mul_valid_i} = 3'b000;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("sim_en", cdb_en_o, 1);
      chk("sim_src", cdb_src_o, k);
      chk("sim_tag", cdb_reg_addr_o, k + 1);
      chk("sim_data", cdb_data_o, 32'h101 + k);
    end
    step();
    chk("sim_en_off", cdb_en_o, 0);

    // continuous contention with a per-unit push/pop scoreboard
    {alu_valid_i, lsu_valid_i, mul_valid_i} = 3'b111;
    for (int i = 0; i < 30; i++) begin
      alu_reg_addr_i = tag_of(0, pc[0]); alu_data_i = data_of(0, pc[0]);
      lsu_reg_addr_i = tag_of(1, pc[1]); lsu_data_i = data_of(1, pc[1]);
      mul_reg_addr_i = tag_of(2, pc[2]); mul_data_i = data_of(2, pc[2]);
      rs = {mul_ready_o, lsu_ready_o, alu_ready_o};
      step();
      for (int u = 0; u < 3; u++) if (rs[u]) pc[u]++;
      if (i == 0) chk("cont_first_idle", cdb_en_o, 0);
      else begin
        s = (i - 1) % 3;
        chk("cont_en", cdb_en_o, 1);
        chk("cont_src", cdb_src_o, s);
        chk("cont_tag", cdb_reg_addr_o, tag_of(s, qc[s]));
        chk("cont_data", cdb_data_o, data_of(s, qc[s]));
        qc[s]++;
      end
    end
    {alu_valid_i, lsu_valid_i, mul_valid_i} = 3'b000;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cdb_en_o) begin
        s = int'(cdb_src_o);
        if (s < 3) begin
          chk("drain_tag", cdb_reg_addr_o, tag_of(s, qc[s]));
          chk("drain_data", cdb_data_o, data_of(s, qc[s]));
          qc[s]++;
        end else chk("drain_src_range", cdb_src_o, 0);
      end
    end
    chk("drain_alu_count", qc[0], pc[0]);
    chk("drain_lsu_count", qc[1], pc[1]);
    chk("drain_mul_count", qc[2], pc[2]);

    // MUL FIFO fills while ALU/LSU keep competing
    reset_pulse();
    alu_valid_i = 1'b1; alu_reg_addr_i = 5'd20; alu_data_i = 32'hA;
    lsu_valid_i = 1'b1; lsu_reg_addr_i = 5'd21; lsu_data_i = 32'hB;
    mul_valid_i = 1'b1; mul_reg_addr_i = 5'd7; mul_data_i = 32'h7007;
    step();
    chk("fill_e1_ready", mul_ready_o, 1);
    chk("fill_e1_en", cdb_en_o, 0);
    mul_reg_addr_i = 5'd8; mul_data_i = 32'h8008;
    step();
    chk("fill_e2_ready", mul_ready_o, 0);
    chk("fill_e2_src", cdb_src_o, 0);
    chk("fill_e2_tag", cdb_reg_addr_o, 20);
    mul_reg_addr_i = 5'd9; mul_data_i = 32'h9009;
    step();
    chk("fill_e3_ready", mul_ready_o, 0);
    chk("fill_e3_src", cdb_src_o, 1);
    chk("fill_e3_tag", cdb_reg_addr_o, 21);
    step();
    chk("fill_e4_src", cdb_src_o, 2);
    chk("fill_e4_tag", cdb_reg_addr_o, 7);
    chk("fill_e4_data", cdb_data_o, 32'h7007);
    chk("fill_e4_ready", mul_ready_o, 1);
    step();
    mul_valid_i = 1'b0;
    chk("fill_e5_src", cdb_src_o, 0);
    chk("fill_e5_ready", mul_ready_o, 0);
    step();
    chk("fill_e6_src", cdb_src_o, 1);
    step();
    chk("fill_e7_src", cdb_src_o, 2);
    chk("fill_e7_tag", cdb_reg_addr_o, 8);
    step();
    step();
    step();
    chk("fill_e10_src", cdb_src_o, 2);
    chk("fill_e10_tag", cdb_reg_addr_o, 9);
    chk("fill_e10_data", cdb_data_o, 32'h9009);
    {alu_valid_i, lsu_valid_i} = 2'b00;

    // reset while ALU and LSU hold results
    for (int i = 0; i < 8; i++) step();
    alu_valid_i = 1'b1; alu_reg_addr_i = 5'd11; alu_data_i = 32'h11;
    lsu_valid_i = 1'b1; lsu_reg_addr_i = 5'd12; lsu_data_i = 32'h12;
    step();
    {alu_valid_i, lsu_valid_i} = 2'b00;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk("mid_rst_en", cdb_en_o, 0);
    chk("mid_rst_tag", cdb_reg_addr_o, 0);
    chk("mid_rst_ready", {mul_ready_o, lsu_ready_o, alu_ready_o}, 3'b111);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_rst_quiet", cdb_en_o, 0);
    end
    alu_valid_i = 1'b1; alu_reg_addr_i = 5'd13; alu_data_i = 32'h13;
    lsu_valid_i = 1'b1; lsu_reg_addr_i = 5'd14; lsu_data_i = 32'h14;
    mul_valid_i = 1'b1; mul_reg_addr_i = 5'd15; mul_data_i = 32'h15;
    step();
    {alu_valid_i, lsu_valid_i, mul_valid_i} = 3'b000;
    step();
    chk("post_rst_en", cdb_en_o, 1);
    chk("post_rst_src", cdb_src_o, 0);
    chk("post_rst_tag", cdb_reg_addr_o, 13);
    step();
    step();
    chk("post_rst_last_tag", cdb_reg_addr_o, 15);

    // tag 0 is an ordinary tag
    lsu_valid_i = 1'b1; lsu_reg_addr_i = 5'd0; lsu_data_i = 32'hA5A5;
    step();
    lsu_valid_i = 1'b0;
    step();
    chk("tag0_en", cdb_en_o, 1);
    chk("tag0_tag", cdb_reg_addr_o, 0);
    chk("tag0_data", cdb_data_o, 32'hA5A5);
    chk("tag0_src", cdb_src_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
